ahb_slave_if_param: RTL

Parametrised AHB slave front-end for the AHB-to-APB bridge, replacing the fixed three-region, 32-bit slave interface. It decodes NUM_SLV equal-sized APB regions from a configurable base address. It qualifies transfers with correct AHB precedence and pipelines address, write data and direction under HREADY control. It also generates the two-cycle AHB ERROR response for unmapped accesses and inserts wait states while the APB side is busy.

---
 rtl/ahb_bridge_pkg.sv | 24 ++
 rtl/ahb_addr_decode.sv | 36 +++
 rtl/ahb_slave_if_param.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ahb_bridge_pkg.sv
// Shared AHB encodings and error-response FSM states for the AHB-to-APB bridge.
// Consumed by ahb_slave_if_param and the bridge FSM.
package ahb_bridge_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [1:0] {
      ERR_IDLE = 2'b00,
      ERR_ERR1 = 2'b01,
      ERR_ERR2 = 2'b10
   } err_state_e;

   // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
   function automatic logic is_active_trans(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational decoder of NUM_SLV equal, contiguous APB regions starting at BASE_ADDR.
// Produces a one-hot region select (all-zero when unmapped) and its OR-reduction.
module ahb_addr_decode #(
   parameter int unsigned     AW          = 32,
   parameter int unsigned     NUM_SLV     = 3,
   parameter logic [AW-1:0]   BASE_ADDR   = 32'h8000_0000,
   parameter logic [AW-1:0]   REGION_SIZE = 32'h0400_0000
) (
   input  logic [AW-1:0]      haddr,
   output logic [NUM_SLV-1:0] temp_selx,
   output logic               in_map
);

   // Four guard bits hold base + 8 regions without wrapping past 2^AW.
   localparam int unsigned   EW       = AW + 4;
   localparam logic [EW-1:0] EXT_BASE = {4'b0000, BASE_ADDR};
   localparam logic [EW-1:0] EXT_SIZE = {4'b0000, REGION_SIZE};
   localparam logic [EW-1:0] SPAN     = {4'b0001, {AW{1'b0}}};

   logic [EW-1:0] ext_addr;
   assign ext_addr = {4'b0000, haddr};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLV; gi = gi + 1) begin : g_region
         localparam logic [EW-1:0] LO     = EXT_BASE + EXT_SIZE * EW'(gi);
         localparam logic [EW-1:0] HI_RAW = LO + EXT_SIZE;
         localparam logic [EW-1:0] HI     = (HI_RAW > SPAN) ? SPAN : HI_RAW;

         assign temp_selx[gi] = (ext_addr >= LO) && (ext_addr < HI);
      end
   endgenerate

   assign in_map = |temp_selx;

endmodule

// File: rtl/ahb_slave_if_param.sv
// Parametrised AHB slave front-end: region decode, HREADY-gated address/data pipeline,
// optional two-cycle ERROR response for unmapped accesses (macro AHB_SLV_ERR_RESP_EN).
module ahb_slave_if_param
   import ahb_bridge_pkg::*;
#(
   parameter int unsigned   AW          = 32,
   parameter int unsigned   DW          = 32,
   parameter int unsigned   NUM_SLV     = 3,
   parameter logic [AW-1:0] BASE_ADDR   = 32'h8000_0000,
   parameter logic [AW-1:0] REGION_SIZE = 32'h0400_0000
) (
   input  logic               hclk,
   input  logic               hreset,
   input  logic               hwrite,
   input  logic               hready_in,
   input  logic [1:0]         htrans,
   input  logic [AW-1:0]      haddr,
   input  logic [DW-1:0]      hwdata,
   input  logic [DW-1:0]      pr_data,
   input  logic               bridge_ready,
   output logic               valid,
   output logic [NUM_SLV-1:0] temp_selx,
   output logic [NUM_SLV-1:0] sel_q,
   output logic [AW-1:0]      haddr1,
   output logic [AW-1:0]      haddr2,
   output logic [DW-1:0]      hwdata1,
   output logic [DW-1:0]      hwdata2,
   output logic               hwrite_reg,
   output logic               hwrite_reg1,
   output logic               hready_out,
   output logic [1:0]         hresp,
   output logic [DW-1:0]      hr_data
);

   logic in_map;
   logic xfer_sampled;
   logic slot_free;

   ahb_addr_decode #(
      .AW          (AW),
      .NUM_SLV     (NUM_SLV),
      .BASE_ADDR   (BASE_ADDR),
      .REGION_SIZE (REGION_SIZE)
   ) u_decode (
      .haddr     (haddr),
      .temp_selx (temp_selx),
      .in_map    (in_map)
   );

   assign xfer_sampled = hready_in && is_active_trans(htrans);
   assign valid        = xfer_sampled && in_map && slot_free;
   assign hr_data      = pr_data;

   // Address phase -> stage 1 -> stage 2; write data trails the address by one phase.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         haddr1      <= '0;
         haddr2      <= '0;
         hwdata1     <= '0;
         hwdata2     <= '0;
         hwrite_reg  <= 1'b0;
         hwrite_reg1 <= 1'b0;
         sel_q       <= '0;
      end else if (hready_in) begin
         haddr1      <= haddr;
         haddr2      <= haddr1;
         hwdata1     <= hwdata;
         hwdata2     <= hwdata1;
         hwrite_reg  <= hwrite;
         hwrite_reg1 <= hwrite_reg;
         sel_q       <= temp_selx;
      end
   end

`ifdef AHB_SLV_ERR_RESP_EN
   err_state_e state_reg;
   err_state_e state_next;

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_reg <= ERR_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      hresp      = HRESP_OKAY;
      hready_out = bridge_ready;
      case (state_reg)
         ERR_IDLE: begin
            if (xfer_sampled && !in_map) begin
               state_next = ERR_ERR1;
            end
         end
         ERR_ERR1: begin
            hresp      = HRESP_ERROR;
            hready_out = 1'b0;
            state_next = ERR_ERR2;
         end
         ERR_ERR2: begin
            hresp      = HRESP_ERROR;
            hready_out = 1'b1;
            state_next = (xfer_sampled && !in_map) ? ERR_ERR1 : ERR_IDLE;
         end
         default: begin
            state_next = ERR_IDLE;
         end
      endcase
      // The bus must see an idle OKAY slave for as long as reset is held.
      if (hreset) begin
         hresp      = HRESP_OKAY;
         hready_out = 1'b1;
      end
   end

   assign slot_free = (state_reg == ERR_IDLE);
`else
   assign hresp      = HRESP_OKAY;
   assign hready_out = hreset ? 1'b1 : bridge_ready;
   assign slot_free  = 1'b1;
`endif

endmodule
